uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter among NUM_REQ byte producers using round-robin arbitration.
- Accepts bytes through per-requester valid/ready handshakes and launches one frame at a time on the transmitter: registered data plus a one-cycle start pulse.
- Waits for frame completion, inserts a programmable inter-frame gap, then grants the next requester.
- A watchdog flags a transmitter that never completes a frame.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 34 +++
 rtl/uart_tx_arbiter.sv | 141 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// The arbiter state enum is kept apart from any transmitter-side state enum.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        START,
        WAIT_DONE,
        GAP
    } arb_state_t;

    // Width of a counter that must hold values 0..max_val (at least one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: the first set request strictly after ptr,
// wrapping around, so the last winner has the lowest priority.
module rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       found
);

    localparam int IW = $clog2(NUM_REQ);

    logic [IW-1:0]      cand [NUM_REQ];
    logic [NUM_REQ-1:0] hit;

    // cand[k] is the requester that sits k+1 places after the pointer.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        assign cand[gi] = IW'((int'(ptr) + gi + 1) % NUM_REQ);
        assign hit[gi]  = req[cand[gi]];
    end

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (hit[i]) begin
                idx   = cand[i];
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte producers,
// with an inter-frame gap and a sticky watchdog on frame completion.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int GAP_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [UART_DATA_W-1:0]         tx_data,
    output logic                           tx_start,
    input  logic                           tx_busy,
    input  logic                           tx_done,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                           active,
    output logic                           timeout_err,
    input  logic                           err_clr
);

    localparam int IW    = $clog2(NUM_REQ);
    localparam int GAP_W = cnt_width(GAP_CYCLES);
    localparam int WD_W  = cnt_width(TIMEOUT_CYCLES);

    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    // The watchdog expires on the cycle its count would step to TIMEOUT_CYCLES-1,
    // i.e. while the register still holds TIMEOUT_CYCLES-2.
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'((TIMEOUT_CYCLES > 1) ? TIMEOUT_CYCLES - 2 : 0);

    arb_state_t             state_reg, state_next;
    logic [IW-1:0]          ptr_reg, ptr_next;
    logic [IW-1:0]          grant_reg, grant_next;
    logic [UART_DATA_W-1:0] data_reg, data_next;
    logic [WD_W-1:0]        wd_reg, wd_next;
    logic [GAP_W-1:0]       gap_reg, gap_next;
    logic                   err_reg, err_next;

    logic [IW-1:0]          pick_idx;
    logic                   pick_found;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req   (req_valid),
        .ptr   (ptr_reg),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            ptr_reg   <= IW'(NUM_REQ - 1);
            grant_reg <= '0;
            data_reg  <= '0;
            wd_reg    <= '0;
            gap_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            grant_reg <= grant_next;
            data_reg  <= data_next;
            wd_reg    <= wd_next;
            gap_reg   <= gap_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        grant_next = grant_reg;
        data_next  = data_reg;
        wd_next    = wd_reg;
        gap_next   = gap_reg;
        // A timeout below overrides this clear in the same cycle.
        err_next   = err_reg & ~err_clr;

        unique case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    grant_next = pick_idx;
                    state_next = GRANT;
                end
            end
            GRANT: begin
                if (req_valid[grant_reg]) begin
                    data_next  = req_data[UART_DATA_W*grant_reg +: UART_DATA_W];
                    ptr_next   = grant_reg;
                    state_next = START;
                end else begin
                    state_next = IDLE;
                end
            end
            START: begin
                if (!tx_busy) begin
                    wd_next    = '0;
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (tx_done) begin
                    gap_next   = '0;
                    state_next = (GAP_CYCLES == 0) ? IDLE : GAP;
                end else if (wd_reg == WD_LAST) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else begin
                    wd_next = wd_reg + 1'b1;
                end
            end
            GAP: begin
                if (gap_reg == GAP_LAST) begin
                    state_next = IDLE;
                end else begin
                    gap_next = gap_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (state_reg == GRANT) begin
            req_ready[grant_reg] = 1'b1;
        end
        tx_start = (state_reg == START) && !tx_busy;
        active   = (state_reg != IDLE);
    end

    assign tx_data     = data_reg;
    assign grant_id    = grant_reg;
    assign timeout_err = err_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a timestamp-based model of the arbitration
// rules is compared every cycle, plus hand-computed checks per scenario.
module tb_uart_tx_arbiter;

    localparam int NR  = 4;
    localparam int GAP = 16;
    localparam int TMO = 100;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data  = '0;
    logic [3:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy   = 1'b0;
    logic        tx_done   = 1'b0;
    logic [1:0]  grant_id;
    logic        active;
    logic        timeout_err;
    logic        err_clr   = 1'b0;

    uart_tx_arbiter #(
        .NUM_REQ        (NR),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .grant_id    (grant_id),
        .active      (active),
        .timeout_err (timeout_err),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- model: arbiter behaviour as timestamps ----------------
    int         m_ptr    = NR - 1;
    int         m_grant  = 0;
    int         m_offer  = -1;   // cycle in which req_ready is due
    int         m_start  = -1;   // cycle of the in-flight tx_start, -1 if none
    int         m_free   = 0;    // first cycle at which the arbiter may pick again
    bit         m_launch = 1'b0; // byte accepted, waiting for a non-busy transmitter
    bit         m_err    = 1'b0;
    logic [7:0] m_data   = '0;

    function automatic int rr_m(input int ptr, input logic [3:0] v);
        for (int k = 1; k <= NR; k++) begin
            if (v[(ptr + k) % NR]) return (ptr + k) % NR;
        end
        return -1;
    endfunction

    task automatic model_step();
        bit         idle;
        bit         tmo;
        int         p;
        logic [3:0] exp_ready;
        if (!rst_n) begin
            m_ptr = NR - 1; m_grant = 0; m_offer = -1; m_start = -1;
            m_free = 0; m_launch = 1'b0; m_err = 1'b0; m_data = '0;
            check("rst_ready", req_ready, 0);
            check("rst_start", tx_start, 0);
            check("rst_data", tx_data, 0);
            check("rst_grant", grant_id, 0);
            check("rst_active", active, 0);
            check("rst_err", timeout_err, 0);
            return;
        end
        idle = (cyc >= m_free) && (m_offer < cyc) && !m_launch && (m_start < 0);
        exp_ready = '0;
        if (cyc == m_offer) exp_ready[m_grant] = 1'b1;
        check("ready", req_ready, exp_ready);
        check("tx_start", tx_start, m_launch && !tx_busy);
        check("active", active, !idle);
        check("tx_data", tx_data, m_data);
        check("grant_id", grant_id, m_grant);
        check("timeout_err", timeout_err, m_err);
        tmo = 1'b0;
        if (idle) begin
            p = rr_m(m_ptr, req_valid);
            if (p >= 0) begin
                m_grant = p;
                m_offer = cyc + 1;
            end
        end else if (cyc == m_offer) begin
            if (req_valid[m_grant]) begin
                m_data   = req_data[8*m_grant +: 8];
                m_ptr    = m_grant;
                m_launch = 1'b1;
            end else begin
                m_free = cyc + 1;
            end
        end else if (m_launch) begin
            if (!tx_busy) begin
                m_launch = 1'b0;
                m_start  = cyc;
            end
        end else if (m_start >= 0 && cyc > m_start) begin
            if (tx_done) begin
                m_free  = cyc + GAP + 1;
                m_start = -1;
            end else if (cyc - m_start == TMO - 1) begin
                tmo     = 1'b1;
                m_free  = cyc + 1;
                m_start = -1;
            end
        end
        m_err = (m_err && !err_clr) || tmo;
    endtask

    initial forever begin
        @(negedge clk);
        model_step();
    end

    // ---------------- monitor: logs strobes and launches ----------------
    int         ready_idx [$];
    int         ready_cyc [$];
    int         start_cyc [$];
    logic [7:0] start_dat [$];

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            for (int i = 0; i < NR; i++) begin
                if (req_ready[i]) begin
                    ready_idx.push_back(i);
                    ready_cyc.push_back(cyc);
                end
            end
            if (tx_start) begin
                start_cyc.push_back(cyc);
                start_dat.push_back(tx_data);
                $display("tx frame: grant=%0d data=%02h cycle=%0d", grant_id, tx_data, cyc);
            end
        end
    end

    // ---------------- transmitter stand-in ----------------
    bit auto_en  = 1'b1;
    int auto_lat = 5;

    initial forever begin
        @(negedge clk);
        if (auto_en && rst_n && tx_start) begin
            repeat (auto_lat) @(posedge clk);
            #1 tx_done = 1'b1;
            @(posedge clk);
            #1 tx_done = 1'b0;
        end
    end

    // ---------------- helpers ----------------
    task automatic clear_logs();
        ready_idx.delete(); ready_cyc.delete();
        start_cyc.delete(); start_dat.delete();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Raise a request mask in cycle c, drop it in c+2 (after the c+1 strobe).
    task automatic pulse_req(input logic [3:0] mask, output int c);
        step();
        c = cyc;
        req_valid = mask;
        step();
        step();
        req_valid = '0;
    endtask

    task automatic wait_ready(input int n, input int budget, input string name);
        int k = 0;
        while (ready_idx.size() < n && k < budget) begin
            @(negedge clk); #1; k++;
        end
        check(name, ready_idx.size(), n);
    endtask

    task automatic wait_starts(input int n, input int budget, input string name);
        int k = 0;
        while (start_cyc.size() < n && k < budget) begin
            @(negedge clk); #1; k++;
        end
        check(name, start_cyc.size(), n);
    endtask

    task automatic wait_idle(output int c, input int budget, input string name);
        int k = 0;
        while (active && k < budget) begin
            @(negedge clk); #1; k++;
        end
        c = cyc;
        check(name, active, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int c, s, d, k;
        int cnt [NR];
        int exp_order [8];
        exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Round-robin fairness with every requester permanently pending.
        clear_logs();
        auto_lat = 5;
        req_data = 32'h44_33_22_11;
        step();
        req_valid = 4'b1111;
        wait_starts(8, 600, "rr_frames");
        step();
        req_valid = '0;
        wait_idle(d, 200, "rr_idle");
        check("rr_count", ready_idx.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check("rr_order", (i < ready_idx.size()) ? ready_idx[i] : -1, exp_order[i]);
            check("rr_data", (i < start_dat.size()) ? start_dat[i] : 8'hxx,
                  8'h11 * (exp_order[i] + 1));
        end
        foreach (cnt[i]) cnt[i] = 0;
        foreach (ready_idx[i]) cnt[ready_idx[i]]++;
        for (int i = 0; i < NR; i++) check("rr_pulses", cnt[i], 2);

        // Wrap-around and skip: after grant 3 only requester 2 is pending.
        clear_logs();
        req_data = 32'h44_5C_22_11;
        pulse_req(4'b0100, c);
        wait_idle(d, 200, "wrap_idle");
        pulse_req(4'b1011, c);
        wait_idle(d, 200, "wrap_idle2");
        check("wrap_count", ready_idx.size(), 2);
        check("wrap_first", (ready_idx.size() > 0) ? ready_idx[0] : -1, 2);
        check("wrap_ptr_next", (ready_idx.size() > 1) ? ready_idx[1] : -1, 3);
        check("wrap_data", (start_dat.size() > 0) ? start_dat[0] : 8'hxx, 8'h5C);

        // Single requester: latency, captured byte and gap length.
        clear_logs();
        auto_lat = 50;
        req_data[7:0] = 8'hA5;
        pulse_req(4'b0001, c);
        wait_starts(1, 20, "single_start");
        s = (start_cyc.size() > 0) ? start_cyc[0] : -1;
        check("single_ready_lat", (ready_cyc.size() > 0) ? ready_cyc[0] - c : -1, 1);
        check("single_start_lat", s - c, 2);
        check("single_data", (start_dat.size() > 0) ? start_dat[0] : 8'hxx, 8'hA5);
        wait_idle(d, 200, "single_idle");
        check("single_idle_cycle", d, s + 50 + GAP + 1);

        // Busy stall: transmitter busy through the first 10 START cycles.
        clear_logs();
        auto_lat = 5;
        step();
        c = cyc;
        req_valid = 4'b0100;
        tx_busy = 1'b1;
        step();
        step();
        req_valid = '0;
        repeat (10) @(posedge clk);
        #1 tx_busy = 1'b0;
        wait_starts(1, 20, "busy_start");
        check("busy_start_cycle", (start_cyc.size() > 0) ? start_cyc[0] : -1, c + 12);
        wait_idle(d, 200, "busy_idle");

        // Withdrawn request: requester 1 drops during its grant; pointer stays at 2.
        clear_logs();
        req_data[15:8] = 8'h3C;
        step();
        c = cyc;
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        step();
        req_valid = 4'b0110;
        step();
        step();
        req_valid = '0;
        wait_starts(1, 20, "wd_start");
        wait_idle(d, 200, "wd_idle");
        check("wd_ready_count", ready_idx.size(), 2);
        check("wd_second_grant", (ready_idx.size() > 1) ? ready_idx[1] : -1, 1);
        check("wd_second_ready", (ready_cyc.size() > 1) ? ready_cyc[1] : -1, c + 3);
        check("wd_start_cycle", (start_cyc.size() > 0) ? start_cyc[0] : -1, c + 4);
        check("wd_start_count", start_cyc.size(), 1);
        check("wd_data", (start_dat.size() > 0) ? start_dat[0] : 8'hxx, 8'h3C);

        // Watchdog: no tx_done at all.
        clear_logs();
        auto_en = 1'b0;
        pulse_req(4'b0001, c);
        wait_starts(1, 20, "tmo_start");
        s = (start_cyc.size() > 0) ? start_cyc[0] : 0;
        k = 0;
        while (!timeout_err && k < 200) begin
            @(negedge clk); #1; k++;
        end
        check("tmo_cycle", cyc, s + TMO);
        check("tmo_active", active, 0);

        // Second timeout coincident with err_clr: set wins.
        clear_logs();
        pulse_req(4'b0001, c);
        wait_starts(1, 20, "tmo2_start");
        s = (start_cyc.size() > 0) ? start_cyc[0] : 0;
        while (cyc < s + TMO - 1) step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("tmo2_set_wins", timeout_err, 1);
        check("tmo2_active", active, 0);
        step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("tmo_clear", timeout_err, 0);

        // tx_done on the expiry cycle counts as completion.
        clear_logs();
        auto_en  = 1'b1;
        auto_lat = TMO - 1;
        pulse_req(4'b0001, c);
        wait_starts(1, 20, "edge_start");
        s = (start_cyc.size() > 0) ? start_cyc[0] : 0;
        wait_idle(d, 300, "edge_idle");
        check("edge_no_err", timeout_err, 0);
        check("edge_idle_cycle", d, s + TMO - 1 + GAP + 1);

        // Asynchronous reset in the middle of a frame.
        clear_logs();
        auto_lat = 50;
        req_data[7:0] = 8'hE7;
        pulse_req(4'b0001, c);
        wait_starts(1, 20, "rst_frame_start");
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_ready", req_ready, 0);
        check("async_start", tx_start, 0);
        check("async_data", tx_data, 0);
        check("async_active", active, 0);
        req_valid = 4'b1010;
        clear_logs();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_ready(1, 20, "post_rst_ready");
        check("post_rst_grant", (ready_idx.size() > 0) ? ready_idx[0] : -1, 1);
        step();
        req_valid = '0;
        wait_idle(d, 300, "post_rst_idle");
        check("post_rst_starts", start_cyc.size(), 1);

        repeat (5) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
